// File: rtl/crc_frame_arbiter.sv
// -----------------------------------------------------------------------------
// crc_frame_arbiter
//
// Shares one multi-step CRC engine between two frame requesters (s0, s1).
// Whole frames are granted round-robin, forwarded beat by beat to the engine,
// and the engine's checksum is returned on a valid/ready result port tagged
// with the requester ID. If the engine never answers, a timeout result
// (crc = 0, res_timeout = 1) is produced instead.
//
// Handshakes: a beat moves on sN_valid && sN_ready in the same cycle; a
// result moves on res_valid && res_ready, and res_* hold steady until then.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   sN_din/valid/first/last   requester beat (N = 0, 1)
//   sN_ready                  beat accepted when valid && ready
//   crc_din/_valid/_first/_last   registered beat towards the engine
//   crc_in, crc_in_valid      engine result
//   res_crc/id/timeout/valid  result towards the consumer
//   res_ready                 consumer ready
//   busy                      high whenever the FSM is not IDLE
//
// Debug: state_q holds the FSM state (state_t) for checkers to bind to.
// -----------------------------------------------------------------------------
module crc_frame_arbiter #(
    parameter int DIN_WIDTH = 32,
    parameter int WIDTH     = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [DIN_WIDTH-1:0] s0_din,
    input  logic                 s0_valid,
    input  logic                 s0_first,
    input  logic                 s0_last,
    output logic                 s0_ready,
    input  logic [DIN_WIDTH-1:0] s1_din,
    input  logic                 s1_valid,
    input  logic                 s1_first,
    input  logic                 s1_last,
    output logic                 s1_ready,
    output logic [DIN_WIDTH-1:0] crc_din,
    output logic                 crc_din_valid,
    output logic                 crc_din_first,
    output logic                 crc_din_last,
    input  logic [WIDTH-1:0]     crc_in,
    input  logic                 crc_in_valid,
    output logic [WIDTH-1:0]     res_crc,
    output logic                 res_id,
    output logic                 res_timeout,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_CRC = 2'd2,
        RESULT   = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t               state_q;
    logic                 grant_q;       // requester owning the current frame
    logic                 prio_q;        // requester favoured on a tie
    logic                 first_pend_q;  // next accepted beat opens the frame
    logic [7:0]           timer_q;
    logic [DIN_WIDTH-1:0] crc_din_q;
    logic                 crc_din_valid_q;
    logic                 crc_din_first_q;
    logic                 crc_din_last_q;
    logic [WIDTH-1:0]     res_crc_q;
    logic                 res_id_q;
    logic                 res_timeout_q;
    logic                 res_valid_q;

    logic                 cand0_d, cand1_d, win_d;
    logic                 g_valid_d, g_last_d, accept_d;
    logic [DIN_WIDTH-1:0] g_din_d;
    logic                 s0_ready_d, s1_ready_d;

    always_comb begin
        cand0_d   = s0_valid && s0_first;
        cand1_d   = s1_valid && s1_first;
        // On a tie the pointer decides; otherwise the lone candidate wins.
        win_d     = (cand0_d && cand1_d) ? prio_q : cand1_d;
        g_valid_d = grant_q ? s1_valid : s0_valid;
        g_din_d   = grant_q ? s1_din   : s0_din;
        g_last_d  = grant_q ? s1_last  : s0_last;
        accept_d  = (state_q == STREAM) && g_valid_d;

        s0_ready_d = 1'b0;
        s1_ready_d = 1'b0;
        if (state_q == STREAM) begin
            s0_ready_d = !grant_q;
            s1_ready_d = grant_q;
        end else if (state_q == IDLE) begin
            // Non-first beats in IDLE belong to no frame: swallow them.
            s0_ready_d = s0_valid && !s0_first;
            s1_ready_d = s1_valid && !s1_first;
        end
        // state_q already reads IDLE during reset; keep the flush path quiet too.
        if (!rstn) begin
            s0_ready_d = 1'b0;
            s1_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= IDLE;
            grant_q         <= 1'b0;
            prio_q          <= 1'b0;
            first_pend_q    <= 1'b0;
            timer_q         <= '0;
            crc_din_q       <= '0;
            crc_din_valid_q <= 1'b0;
            crc_din_first_q <= 1'b0;
            crc_din_last_q  <= 1'b0;
            res_crc_q       <= '0;
            res_id_q        <= 1'b0;
            res_timeout_q   <= 1'b0;
            res_valid_q     <= 1'b0;
        end else begin
            // Beat strobes are single-cycle pulses.
            crc_din_valid_q <= 1'b0;
            crc_din_first_q <= 1'b0;
            crc_din_last_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cand0_d || cand1_d) begin
                        grant_q      <= win_d;
                        first_pend_q <= 1'b1;
                        state_q      <= STREAM;
                    end
                end
                STREAM: begin
                    if (accept_d) begin
                        crc_din_q       <= g_din_d;
                        crc_din_valid_q <= 1'b1;
                        // Only the opening beat carries first; later first flags are masked.
                        crc_din_first_q <= first_pend_q;
                        crc_din_last_q  <= g_last_d;
                        first_pend_q    <= 1'b0;
                        if (g_last_d) begin
                            timer_q <= '0;
                            state_q <= WAIT_CRC;
                        end
                    end
                end
                WAIT_CRC: begin
                    if (crc_in_valid) begin
                        res_crc_q     <= crc_in;
                        res_timeout_q <= 1'b0;
                        res_id_q      <= grant_q;
                        res_valid_q   <= 1'b1;
                        state_q       <= RESULT;
                    end else if (!crc_din_last_q) begin
                        // The timer holds at 0 while the last beat is still on crc_din.
                        if (timer_q == TMO_LAST) begin
                            res_crc_q     <= '0;
                            res_timeout_q <= 1'b1;
                            res_id_q      <= grant_q;
                            res_valid_q   <= 1'b1;
                            state_q       <= RESULT;
                        end else begin
                            timer_q <= timer_q + 8'd1;
                        end
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        prio_q      <= !grant_q;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s0_ready      = s0_ready_d;
    assign s1_ready      = s1_ready_d;
    assign crc_din       = crc_din_q;
    assign crc_din_valid = crc_din_valid_q;
    assign crc_din_first = crc_din_first_q;
    assign crc_din_last  = crc_din_last_q;
    assign res_crc       = res_crc_q;
    assign res_id        = res_id_q;
    assign res_timeout   = res_timeout_q;
    assign res_valid     = res_valid_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_crc_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_crc_frame_arbiter
//
// Directed bench for crc_frame_arbiter: requester drivers, a model CRC engine
// that answers a fixed number of cycles after crc_din_last, a beat scoreboard
// fed with hand-written expected beats, and result checks per frame.
// -----------------------------------------------------------------------------
module tb_crc_frame_arbiter;

    localparam int DW = 32;
    localparam int CW = 32;

    logic          clk;
    logic          rstn;
    logic [DW-1:0] s0_din, s1_din;
    logic          s0_valid, s0_first, s0_last, s0_ready;
    logic          s1_valid, s1_first, s1_last, s1_ready;
    logic [DW-1:0] crc_din;
    logic          crc_din_valid, crc_din_first, crc_din_last;
    logic [CW-1:0] crc_in;
    logic          crc_in_valid;
    logic [CW-1:0] res_crc;
    logic          res_id, res_timeout, res_valid, res_ready;
    logic          busy;

    crc_frame_arbiter #(.DIN_WIDTH(DW), .WIDTH(CW), .TIMEOUT(16)) dut (
        .clk(clk), .rstn(rstn),
        .s0_din(s0_din), .s0_valid(s0_valid), .s0_first(s0_first),
        .s0_last(s0_last), .s0_ready(s0_ready),
        .s1_din(s1_din), .s1_valid(s1_valid), .s1_first(s1_first),
        .s1_last(s1_last), .s1_ready(s1_ready),
        .crc_din(crc_din), .crc_din_valid(crc_din_valid),
        .crc_din_first(crc_din_first), .crc_din_last(crc_din_last),
        .crc_in(crc_in), .crc_in_valid(crc_in_valid),
        .res_crc(res_crc), .res_id(res_id), .res_timeout(res_timeout),
        .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
    );

    // ---------------- clock / reset / bookkeeping ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard: expected beats {first, last, din} ----------------
    logic [DW+1:0] exp_q[$];
    int beat_cnt  = 0;
    int first_cyc = 0;
    int last_cyc  = 0;
    int res_cyc   = 0;

    always @(negedge clk) begin
        if (rstn && crc_din_valid) begin
            beat_cnt++;
            if (crc_din_first) first_cyc = cyc;
            if (crc_din_last)  last_cyc  = cyc;
            check_eq("beat_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                logic [DW+1:0] e;
                e = exp_q.pop_front();
                check_eq("crc_din_beat", {crc_din_first, crc_din_last, crc_din}, e);
            end
        end
    end

    // s1 must never be ready while s0 owns a frame.
    logic s0_active = 1'b0;
    logic s1_leak   = 1'b0;
    always @(negedge clk) if (s0_active && s1_ready) s1_leak = 1'b1;

    // ---------------- model engine ----------------
    int            eng_delay = 2;   // < 0: never answers
    logic [CW-1:0] eng_crc   = '0;

    initial begin
        crc_in_valid = 1'b0;
        crc_in       = '0;
        forever begin
            @(negedge clk);
            if (rstn && crc_din_valid && crc_din_last && eng_delay >= 0) begin
                for (int k = 0; k < eng_delay; k++) @(posedge clk);
                #1;
                crc_in_valid = 1'b1;
                crc_in       = eng_crc;
                @(posedge clk);
                #1;
                crc_in_valid = 1'b0;
                crc_in       = '0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit id, input bit v, input logic [DW-1:0] d, input bit f, input bit l);
        if (id) begin
            s1_valid = v; s1_din = d; s1_first = f; s1_last = l;
        end else begin
            s0_valid = v; s0_din = d; s0_first = f; s0_last = l;
        end
    endtask

    // Sends a 1- or 2-beat frame; mid_first raises first on the second beat.
    task automatic send_frame(input bit id, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input int nbeats, input bit mid_first);
        int   waited;
        logic got;
        if (!id) s0_active = 1'b1;
        for (int b = 0; b < nbeats; b++) begin
            drive(id, 1'b1, (b == 0) ? d0 : d1, (b == 0) || mid_first, b == nbeats - 1);
            waited = 0;
            do begin
                @(negedge clk);
                got = id ? s1_ready : s0_ready;
                waited++;
            end while (!got && waited < 200);
            if (!got) begin
                check_eq(id ? "ready_wait_s1" : "ready_wait_s0", got, 1'b1);
                break;
            end
            @(posedge clk);
            #1;
        end
        drive(id, 1'b0, '0, 1'b0, 1'b0);
        if (!id) s0_active = 1'b0;
    endtask

    // Waits for res_valid, checks the result, returns after the handshake edge.
    task automatic wait_result(input bit id, input bit tmo, input logic [CW-1:0] crc, input string tag);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!res_valid && w < 300);
        check_eq({tag, "_valid"}, res_valid, 1'b1);
        if (res_valid) begin
            res_cyc = cyc;
            check_eq({tag, "_id"}, res_id, id);
            check_eq({tag, "_timeout"}, res_timeout, tmo);
            check_eq({tag, "_crc"}, res_crc, crc);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    int n_before;
    int t0;
    int res_seen;

    initial begin
        rstn = 1'b0;
        res_ready = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);

        // Reset values
        repeat (2) @(negedge clk);
        check_eq("rst_flags", {s0_ready, s1_ready, crc_din_valid, crc_din_first, crc_din_last,
                               res_valid, res_id, res_timeout, busy}, 9'b0);
        check_eq("rst_crc_din", crc_din, '0);
        check_eq("rst_res_crc", res_crc, '0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Contention right after reset: s0 first, then s1
        eng_crc = 32'h11112222;
        exp_q.push_back({1'b1, 1'b0, 32'hA0000001});
        exp_q.push_back({1'b0, 1'b1, 32'hA0000002});
        exp_q.push_back({1'b1, 1'b0, 32'h78780000});
        exp_q.push_back({1'b0, 1'b1, 32'h00010032});
        s1_leak = 1'b0;
        fork
            send_frame(1'b0, 32'hA0000001, 32'hA0000002, 2, 1'b0);
            send_frame(1'b1, 32'h78780000, 32'h00010032, 2, 1'b0);
            begin
                wait_result(1'b0, 1'b0, 32'h11112222, "cont0");
                wait_result(1'b1, 1'b0, 32'h11112222, "cont1");
            end
        join
        check_eq("cont_s1_ready_held", s1_leak, 1'b0);

        // Fairness: both keep requesting, grants alternate 0,1,0,1
        eng_crc = 32'h33334444;
        exp_q.push_back({1'b1, 1'b1, 32'hC0DE0001});
        exp_q.push_back({1'b1, 1'b1, 32'hC0DE0002});
        exp_q.push_back({1'b1, 1'b1, 32'hC0DE0003});
        exp_q.push_back({1'b1, 1'b1, 32'hC0DE0004});
        fork
            begin
                send_frame(1'b0, 32'hC0DE0001, '0, 1, 1'b0);
                send_frame(1'b0, 32'hC0DE0003, '0, 1, 1'b0);
            end
            begin
                send_frame(1'b1, 32'hC0DE0002, '0, 1, 1'b0);
                send_frame(1'b1, 32'hC0DE0004, '0, 1, 1'b0);
            end
            begin
                wait_result(1'b0, 1'b0, 32'h33334444, "fair0");
                wait_result(1'b1, 1'b0, 32'h33334444, "fair1");
                wait_result(1'b0, 1'b0, 32'h33334444, "fair2");
                wait_result(1'b1, 1'b0, 32'h33334444, "fair3");
            end
        join

        // Single frame from s0 with latency checks
        eng_crc = 32'hCBF43926;
        exp_q.push_back({1'b1, 1'b0, 32'h12004578});
        exp_q.push_back({1'b0, 1'b1, 32'h368F0002});
        t0 = cyc;
        fork
            send_frame(1'b0, 32'h12004578, 32'h368F0002, 2, 1'b0);
            wait_result(1'b0, 1'b0, 32'hCBF43926, "single");
        join
        check_eq("single_first_lat", first_cyc - t0, 2);
        check_eq("single_res_lat", res_cyc - last_cyc, 3);
        check_eq("single_idle_busy", busy, 1'b0);

        // Timeout: engine silent
        eng_delay = -1;
        exp_q.push_back({1'b1, 1'b1, 32'h00000007});
        fork
            send_frame(1'b1, 32'h00000007, '0, 1, 1'b0);
            wait_result(1'b1, 1'b1, 32'h0, "tmo");
        join
        check_eq("tmo_lat", res_cyc - last_cyc, 17);
        eng_delay = 2;

        // Mid-frame first flag is masked
        eng_crc = 32'h5A5A5A5A;
        exp_q.push_back({1'b1, 1'b0, 32'h11110000});
        exp_q.push_back({1'b0, 1'b1, 32'h22220000});
        fork
            send_frame(1'b1, 32'h11110000, 32'h22220000, 2, 1'b1);
            wait_result(1'b1, 1'b0, 32'h5A5A5A5A, "midf");
        join

        // Stray non-first beat in IDLE is flushed, nothing forwarded
        n_before = beat_cnt;
        drive(1'b0, 1'b1, 32'hBAD00BAD, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("stray_ready", s0_ready, 1'b1);
        check_eq("stray_busy", busy, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("stray_not_forwarded", beat_cnt - n_before, 0);
        check_eq("stray_idle", busy, 1'b0);
        @(posedge clk); #1;

        // Result backpressure: res_ready low for 5 cycles, s1 waiting meanwhile
        res_ready = 1'b0;
        eng_crc = 32'h0BADF00D;
        exp_q.push_back({1'b1, 1'b1, 32'hA5A50001});
        send_frame(1'b0, 32'hA5A50001, '0, 1, 1'b0);
        res_seen = 0;
        do begin
            @(negedge clk);
            res_seen++;
        end while (!res_valid && res_seen < 100);
        check_eq("bp_valid", res_valid, 1'b1);
        check_eq("bp_id", res_id, 1'b0);
        check_eq("bp_crc", res_crc, 32'h0BADF00D);
        @(posedge clk); #1;
        exp_q.push_back({1'b1, 1'b1, 32'hB5B50001});
        fork
            send_frame(1'b1, 32'hB5B50001, '0, 1, 1'b0);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check_eq("bp_hold", {res_valid, res_id, res_timeout, res_crc},
                             {1'b1, 1'b0, 1'b0, 32'h0BADF00D});
                    check_eq("bp_no_grant", {s1_ready, crc_din_valid, busy}, 3'b001);
                    @(posedge clk); #1;
                end
                res_ready = 1'b1;
                @(negedge clk);
                check_eq("bp_valid_at_hs", res_valid, 1'b1);
                @(posedge clk); #1;
                check_eq("bp_released", res_valid, 1'b0);
                wait_result(1'b1, 1'b0, 32'h0BADF00D, "bp_s1");
            end
        join

        // One s0 frame so the pointer now favours s1
        eng_crc = 32'h600D600D;
        exp_q.push_back({1'b1, 1'b1, 32'h0000AAAA});
        fork
            send_frame(1'b0, 32'h0000AAAA, '0, 1, 1'b0);
            wait_result(1'b0, 1'b0, 32'h600D600D, "pre_rst");
        join

        // Reset in the middle of a frame
        exp_q.push_back({1'b1, 1'b0, 32'h55550001});
        drive(1'b0, 1'b1, 32'h55550001, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("mid_busy", busy, 1'b1);
        @(posedge clk); #1;
        rstn = 1'b0;
        drive(1'b0, 1'b1, 32'h55550002, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 32'h66660001, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("mrst_flags", {s0_ready, s1_ready, crc_din_valid, crc_din_first, crc_din_last,
                                    res_valid, res_id, res_timeout, busy}, 9'b0);
            check_eq("mrst_data", {crc_din, res_crc}, 64'h0);
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        rstn = 1'b1;
        res_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (res_valid) res_seen++;
        end
        check_eq("mrst_no_result", res_seen, 0);
        @(posedge clk); #1;
        eng_crc = 32'h0F0F0F0F;
        exp_q.push_back({1'b1, 1'b1, 32'h77770000});
        exp_q.push_back({1'b1, 1'b1, 32'h88880000});
        fork
            send_frame(1'b0, 32'h77770000, '0, 1, 1'b0);
            send_frame(1'b1, 32'h88880000, '0, 1, 1'b0);
            begin
                wait_result(1'b0, 1'b0, 32'h0F0F0F0F, "post_rst0");
                wait_result(1'b1, 1'b0, 32'h0F0F0F0F, "post_rst1");
            end
        join

        repeat (3) @(negedge clk);
        check_eq("beats_left", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
